branch_predict_tracker: RTL and testbench

//  Tracks conditional branches from fetch to resolution, between fetch and the 2-bit BHT.
//  - Fetch pushes {BHT index, predicted direction} into an in-order FIFO.
//  - EX pops the oldest entry with the actual outcome.
//  - Block compares prediction vs outcome, raises a mispredict flush and drives the BHT write port.

---
 rtl/branch_predict_tracker.sv | 122 ++++++++++++
 tb/tb_branch_predict_tracker.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_tracker.sv
// In-order tracker for predicted conditional branches: fetch pushes {BHT index, prediction},
// EX pops the oldest entry, and the block raises mispredict flushes and BHT updates.
// Optional macro BPT_STATS_EN adds saturating branch and mispredict counters.
module branch_predict_tracker #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     fetch_valid,
  input  logic [IDX_W-1:0]         fetch_idx,
  input  logic                     fetch_pred,
  output logic                     fetch_stall,
  input  logic                     resolve_valid,
  input  logic                     resolve_taken,
  output logic                     mispredict,
  output logic                     mispred_taken,
  output logic                     upd_valid,
  output logic [IDX_W-1:0]         upd_addr,
  output logic                     upd_taken,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     underflow_err
`ifdef BPT_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_branches,
  output logic [CNT_W-1:0]         stat_mispred
`endif
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("branch_predict_tracker: DEPTH must be a power of 2 >= 2 and CNT_W >= 1");
  end

  // Each slot holds {BHT index, predicted direction}; contents need no reset.
  logic [IDX_W:0]     mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr_nxt;
  logic [PTR_W-1:0]   rd_ptr_nxt;
  logic               empty;
  logic               full;
  logic               pop;
  logic               push;
  logic               flush_now;
  logic               underflow;
  logic [IDX_W-1:0]   head_idx;
  logic               head_pred;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign pop       = resolve_valid & ~empty;
  assign underflow = resolve_valid & empty;
  assign {head_idx, head_pred} = mem[rd_ptr[AW-1:0]];
  assign flush_now = pop & (head_pred != resolve_taken);

  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign fetch_stall = full & ~pop;
  // A push alongside a flush belongs to the wrong path and is dropped.
  assign push        = fetch_valid & ~fetch_stall & ~flush_now;

  assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
  assign wr_ptr_nxt = flush_now ? rd_ptr + PTR_W'(1) : wr_ptr + PTR_W'(push);
  assign occupancy  = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {fetch_idx, fetch_pred};
    end
  end

  // Registered stage: pointers, BHT update, flush pulse, sticky underflow.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      upd_valid     <= 1'b0;
      upd_addr      <= '0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      mispred_taken <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr_nxt;
      rd_ptr        <= rd_ptr_nxt;
      upd_valid     <= pop;
      mispredict    <= flush_now;
      underflow_err <= underflow_err | underflow;
      if (pop) begin
        upd_addr  <= head_idx;
        upd_taken <= resolve_taken;
      end
      if (flush_now) begin
        mispred_taken <= resolve_taken;
      end
    end
  end

`ifdef BPT_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (pop) begin
        stat_branches <= sat_inc(stat_branches);
      end
      if (flush_now) begin
        stat_mispred <= sat_inc(stat_mispred);
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_predict_tracker.sv
// Scoreboard bench for branch_predict_tracker: a queue model predicts each cycle's
// update, flush, occupancy and stall, which are checked one cycle after stimulus.
module tb_branch_predict_tracker;

  localparam int DEPTH = 4;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             arst_n;
  logic             fetch_valid;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_pred;
  logic             fetch_stall;
  logic             resolve_valid;
  logic             resolve_taken;
  logic             mispredict;
  logic             mispred_taken;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_addr;
  logic             upd_taken;
  logic [2:0]       occupancy;
  logic             underflow_err;

  branch_predict_tracker #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(16)) dut (
    .clk(clk), .arst_n(arst_n),
    .fetch_valid(fetch_valid), .fetch_idx(fetch_idx), .fetch_pred(fetch_pred),
    .fetch_stall(fetch_stall),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .mispred_taken(mispred_taken),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .occupancy(occupancy), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic             pred;
  } ent_t;

  typedef struct {
    logic             uv;
    logic [IDX_W-1:0] ua;
    logic             ut;
    logic             mp;
    logic             mt;
    logic [2:0]       occ;
    logic             st;
    logic             obs_st;
    logic             uf;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  logic uf_m;
  int   total = 0;
  int   bad   = 0;

  // Drive one cycle of stimulus, push the model's expectation, and advance past the edge.
  task automatic step(input logic fv, input logic [IDX_W-1:0] fi, input logic fp,
                      input logic rv, input logic rt);
    exp_t e;
    ent_t h;
    logic pop;
    logic push;
    fetch_valid   = fv;
    fetch_idx     = fi;
    fetch_pred    = fp;
    resolve_valid = rv;
    resolve_taken = rt;
    #1;
    e.obs_st = fetch_stall;
    pop  = rv && (mq.size() > 0);
    e.st = (mq.size() == DEPTH) && !pop;
    e.uv = pop;
    e.ua = '0;
    e.ut = rt;
    e.mp = 1'b0;
    e.mt = rt;
    if (pop) begin
      h    = mq.pop_front();
      e.ua = h.idx;
      e.mp = (h.pred != rt);
    end
    if (rv && !pop) uf_m = 1'b1;
    if (e.mp) mq.delete();
    push = fv && !e.st && !e.mp;
    if (push) mq.push_back('{idx: fi, pred: fp});
    e.occ = 3'(mq.size());
    e.uf  = uf_m;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    fetch_valid = 1'b1; fetch_idx = 5'd4; fetch_pred = 1'b0; resolve_valid = 1'b0; resolve_taken = 1'b0;
    @(posedge clk); #1;
    fetch_valid = 1'b0; resolve_valid = 1'b1; resolve_taken = 1'b1;
    @(posedge clk); #1;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    total++;
    if ({mispredict, upd_valid, upd_addr} !== {1'b1, 1'b1, 5'd4}) begin
      bad++;
      $display("FAIL %s_pre got mp/uv/addr=%b/%b/%0d exp 1/1/4", tag, mispredict, upd_valid, upd_addr);
    end
    #2 arst_n = 1'b0;
    #1;
    total++;
    if ({mispredict, mispred_taken, upd_valid, upd_addr, upd_taken, underflow_err, occupancy, fetch_stall} !== '0) begin
      bad++;
      $display("FAIL %s_async got mp=%b mt=%b uv=%b ua=%0d ut=%b uf=%b occ=%0d st=%b exp all 0",
               tag, mispredict, mispred_taken, upd_valid, upd_addr, upd_taken, underflow_err, occupancy, fetch_stall);
    end
    mq.delete();
    uf_m = 1'b0;
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_correct;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: step(1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        1: step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        default: step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      total++;
      if ({upd_valid, mispredict, occupancy, e.obs_st, underflow_err} !== {e.uv, e.mp, e.occ, e.st, e.uf}) begin
        bad++;
        $display("FAIL correct_ctrl[%0d] got uv/mp/occ/st/uf=%b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 upd_valid, mispredict, occupancy, e.obs_st, underflow_err, e.uv, e.mp, e.occ, e.st, e.uf);
      end
      if (e.uv) begin
        total++;
        if ({upd_addr, upd_taken} !== {e.ua, e.ut}) begin
          bad++;
          $display("FAIL correct_upd[%0d] got addr=%0d taken=%b exp addr=%0d taken=%b", i, upd_addr, upd_taken, e.ua, e.ut);
        end
      end
    end
  endtask

  task automatic test_mispredict;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: step(1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
        1: step(1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        2: step(1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        3: step(1'b1, 5'd11, 1'b1, 1'b1, 1'b1);
        default: step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      total++;
      if ({upd_valid, mispredict, occupancy, e.obs_st, underflow_err} !== {e.uv, e.mp, e.occ, e.st, e.uf}) begin
        bad++;
        $display("FAIL mispred_ctrl[%0d] got uv/mp/occ/st/uf=%b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 upd_valid, mispredict, occupancy, e.obs_st, underflow_err, e.uv, e.mp, e.occ, e.st, e.uf);
      end
      if (e.uv) begin
        total++;
        if ({upd_addr, upd_taken} !== {e.ua, e.ut}) begin
          bad++;
          $display("FAIL mispred_upd[%0d] got addr=%0d taken=%b exp addr=%0d taken=%b", i, upd_addr, upd_taken, e.ua, e.ut);
        end
      end
      if (e.mp) begin
        total++;
        if (mispred_taken !== e.mt) begin
          bad++;
          $display("FAIL mispred_taken[%0d] got=%b exp=%b", i, mispred_taken, e.mt);
        end
      end
    end
  endtask

  task automatic test_full;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      if (i < 4)       step(1'b1, 5'(i + 1), 1'b0, 1'b0, 1'b0);
      else if (i == 4) step(1'b1, 5'd20, 1'b1, 1'b0, 1'b0);
      else if (i == 5) step(1'b1, 5'd6, 1'b0, 1'b1, 1'b0);
      else if (i < 10) step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      else             step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front();
      total++;
      if ({upd_valid, mispredict, occupancy, e.obs_st, underflow_err} !== {e.uv, e.mp, e.occ, e.st, e.uf}) begin
        bad++;
        $display("FAIL full_ctrl[%0d] got uv/mp/occ/st/uf=%b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 upd_valid, mispredict, occupancy, e.obs_st, underflow_err, e.uv, e.mp, e.occ, e.st, e.uf);
      end
      if (e.uv) begin
        total++;
        if ({upd_addr, upd_taken} !== {e.ua, e.ut}) begin
          bad++;
          $display("FAIL full_upd[%0d] got addr=%0d taken=%b exp addr=%0d taken=%b", i, upd_addr, upd_taken, e.ua, e.ut);
        end
      end
    end
  endtask

  task automatic test_wrap;
    exp_t e;
    logic fv, fp, rv, rt;
    logic [IDX_W-1:0] fi;
    for (int i = 0; i < 80; i++) begin
      fi = 5'($urandom);
      fp = 1'($urandom);
      if (i < 20) begin
        fv = (i % 2 == 0);
        fi = 5'((i / 2) * 3 + 1);
        fp = 1'(i / 2);
        rv = (i % 2 == 1);
        rt = (mq.size() > 0) ? mq[0].pred : 1'b0;
      end else if (i < 60) begin
        fv = 1'($urandom);
        rv = (mq.size() > 0) && ($urandom_range(0, 2) != 0);
        rt = (mq.size() > 0) ? (mq[0].pred ^ ($urandom_range(0, 3) == 0)) : 1'b0;
      end else begin
        fv = 1'b0;
        rv = (mq.size() > 0);
        rt = (mq.size() > 0) ? mq[0].pred : 1'b0;
      end
      step(fv, fi, fp, rv, rt);
      e = exp_q.pop_front();
      total++;
      if ({upd_valid, mispredict, occupancy, e.obs_st, underflow_err} !== {e.uv, e.mp, e.occ, e.st, e.uf}) begin
        bad++;
        $display("FAIL wrap_ctrl[%0d] got uv/mp/occ/st/uf=%b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 upd_valid, mispredict, occupancy, e.obs_st, underflow_err, e.uv, e.mp, e.occ, e.st, e.uf);
      end
      if (e.uv) begin
        total++;
        if ({upd_addr, upd_taken} !== {e.ua, e.ut}) begin
          bad++;
          $display("FAIL wrap_upd[%0d] got addr=%0d taken=%b exp addr=%0d taken=%b", i, upd_addr, upd_taken, e.ua, e.ut);
        end
      end
      if (e.mp) begin
        total++;
        if (mispred_taken !== e.mt) begin
          bad++;
          $display("FAIL wrap_mt[%0d] got=%b exp=%b", i, mispred_taken, e.mt);
        end
      end
    end
  endtask

  task automatic test_underflow;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: step(1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        1: step(1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
        2: step(1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        default: step(1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      endcase
      e = exp_q.pop_front();
      total++;
      if ({upd_valid, mispredict, occupancy, e.obs_st, underflow_err} !== {e.uv, e.mp, e.occ, e.st, e.uf}) begin
        bad++;
        $display("FAIL underflow_ctrl[%0d] got uv/mp/occ/st/uf=%b/%b/%0d/%b/%b exp %b/%b/%0d/%b/%b", i,
                 upd_valid, mispredict, occupancy, e.obs_st, underflow_err, e.uv, e.mp, e.occ, e.st, e.uf);
      end
      if (e.uv) begin
        total++;
        if ({upd_addr, upd_taken} !== {e.ua, e.ut}) begin
          bad++;
          $display("FAIL underflow_upd[%0d] got addr=%0d taken=%b exp addr=%0d taken=%b", i, upd_addr, upd_taken, e.ua, e.ut);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n = 1'b0;
    fetch_valid = 1'b0; fetch_idx = '0; fetch_pred = 1'b0;
    resolve_valid = 1'b0; resolve_taken = 1'b0;
    uf_m = 1'b0;
    #12;
    total++;
    if ({mispredict, mispred_taken, upd_valid, upd_addr, upd_taken, underflow_err, occupancy, fetch_stall} !== '0) begin
      bad++;
      $display("FAIL reset_state got mp=%b uv=%b ua=%0d uf=%b occ=%0d st=%b exp all 0",
               mispredict, upd_valid, upd_addr, underflow_err, occupancy, fetch_stall);
    end
    @(negedge clk) arst_n = 1'b1;
    @(posedge clk); #1;
    test_correct();
    test_mispredict();
    test_reset("reset_mid");
    test_full();
    test_wrap();
    test_underflow();
    test_reset("reset_after_uf");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
